// File: rtl/fir_interp_polyphase.sv
// fir_interp_polyphase: polyphase interpolating FIR with valid/ready on both sides
// Each accepted sample yields INTERP_FACTOR outputs, one per polyphase branch.
// Ports:
//   clk, arst_n         clock, asynchronous active-low reset
//   bypass              1 = zero-stuffing upsampler, 0 = filter (latched per sample)
//   coeff               flat signed coefficient bus, coeff j at [j*COEFF_WORD_SIZE +: COEFF_WORD_SIZE]
//   data_in, valid_in   input sample and its valid
//   ready_out           block accepts data_in this cycle
//   data_out, phase_out registered output sample and its polyphase index
//   valid_out           data_out valid
//   ready_in            downstream accepts data_out
module fir_interp_polyphase #(
   parameter int INPUT_WORD_SIZE = 16,
   parameter int COEFF_WORD_SIZE = 16,
   parameter int N_COEFFS        = 8,
   parameter int INTERP_FACTOR   = 2,
   localparam int TAPS             = N_COEFFS / INTERP_FACTOR,
   localparam int OUTPUT_WORD_SIZE = INPUT_WORD_SIZE + COEFF_WORD_SIZE + $clog2(TAPS),
   localparam int PW               = $clog2(INTERP_FACTOR)
) (
   input  logic                                  clk,
   input  logic                                  arst_n,
   input  logic                                  bypass,
   input  logic [N_COEFFS*COEFF_WORD_SIZE-1:0]   coeff,
   input  logic [INPUT_WORD_SIZE-1:0]            data_in,
   input  logic                                  valid_in,
   output logic                                  ready_out,
   output logic [OUTPUT_WORD_SIZE-1:0]           data_out,
   output logic [PW-1:0]                         phase_out,
   output logic                                  valid_out,
   input  logic                                  ready_in
);
   localparam int OW = OUTPUT_WORD_SIZE;
   localparam int CW = COEFF_WORD_SIZE;

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                      state, state_n;
   logic [PW-1:0]               phase, phase_n;
   logic                        byp_q, ld, last, in_xfer;
   logic signed [INPUT_WORD_SIZE-1:0] dl [TAPS];
   logic signed [OW-1:0]        acc, y;

   assign ld        = !valid_out || ready_in;
   assign last      = phase == PW'(INTERP_FACTOR - 1);
   // Accepting on the last phase's load keeps output gap-free at full rate.
   assign ready_out = (state == IDLE) || (last && ld);
   assign in_xfer   = valid_in && ready_out;

   always_comb begin
      acc = '0;
      for (int k = 0; k < TAPS; k++)
         acc = acc + OW'(signed'(coeff[(k*INTERP_FACTOR + int'(phase))*CW +: CW])) * OW'(dl[k]);
      y = byp_q ? ((phase == '0) ? OW'(dl[0]) <<< (CW - 1) : '0) : acc;
   end

   always_comb begin
      state_n = (state == IDLE) ? (in_xfer ? EMIT : IDLE)
                                : ((ld && last && !in_xfer) ? IDLE : EMIT);
      phase_n = (state == EMIT && ld && !last) ? phase + 1'b1
                                               : ((state == EMIT && !ld) ? phase : '0);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state     <= IDLE;
         phase     <= '0;
         byp_q     <= 1'b0;
         data_out  <= '0;
         phase_out <= '0;
         valid_out <= 1'b0;
         for (int k = 0; k < TAPS; k++) dl[k] <= '0;
      end else begin
         state <= state_n;
         phase <= phase_n;
         // The delay line shifts in bypass too, so a mode switch needs no refill.
         if (in_xfer) begin
            byp_q <= bypass;
            dl[0] <= data_in;
            for (int k = 1; k < TAPS; k++) dl[k] <= dl[k-1];
         end
         if (ld) begin
            valid_out <= state == EMIT;
            if (state == EMIT) begin
               data_out  <= y;
               phase_out <= phase;
            end
         end
      end
   end
endmodule

// File: tb/tb_fir_interp_polyphase.sv
// tb_fir_interp_polyphase: directed bench for fir_interp_polyphase (L=2, N=8)
module tb_fir_interp_polyphase;
   logic          clk = 0;
   logic          arst_n = 0;
   logic          bypass = 0;
   logic [127:0]  coeff = '0;
   logic [15:0]   data_in = '0;
   logic          valid_in = 0;
   logic          ready_out;
   logic [33:0]   data_out;
   logic [0:0]    phase_out;
   logic          valid_out;
   logic          ready_in = 1;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] in_data[$];
   logic        in_byp[$];
   logic [33:0] q_data[$];
   logic [0:0]  q_phase[$];

   fir_interp_polyphase dut (
      .clk(clk), .arst_n(arst_n), .bypass(bypass), .coeff(coeff),
      .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
      .data_out(data_out), .phase_out(phase_out), .valid_out(valid_out),
      .ready_in(ready_in)
   );

   always #5 clk = ~clk;

   // Inputs change at posedge+1, so a negedge sample predicts the next edge's transfer.
   always @(negedge clk)
      if (arst_n && valid_out && ready_in) begin
         q_data.push_back(data_out);
         q_phase.push_back(phase_out);
      end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      valid_in = 0;
      ready_in = 1;
      bypass   = 0;
      arst_n   = 0;
      repeat (2) @(posedge clk);
      #1 arst_n = 1;
      q_data.delete();
      q_phase.delete();
   endtask

   task automatic set_ramp_coeffs();
      for (int j = 0; j < 8; j++) coeff[j*16 +: 16] = 16'(j + 1);
   endtask

   task automatic feed();
      logic acc;
      for (int i = 0; i < in_data.size(); i++) begin
         data_in  = in_data[i];
         bypass   = in_byp[i];
         valid_in = 1;
         acc = 0;
         for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = ready_out;
            @(posedge clk);
            #1;
         end
         n_cmp++;
         if (!acc) begin
            n_err++;
            $display("FAIL feed_timeout: sample %0d not accepted, ready_out=%b required 1", i, ready_out);
         end
      end
      valid_in = 0;
      in_data.delete();
      in_byp.delete();
   endtask

   task automatic drain(input int n);
      valid_in = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_impulse(input string tag);
      logic [33:0] exp;
      do_reset();
      set_ramp_coeffs();
      ready_in = 1;
      in_data = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
      in_byp  = '{0, 0, 0, 0, 0};
      feed();
      drain(6);
      n_cmp++;
      if (q_data.size() !== 10) begin
         n_err++;
         $display("FAIL %s_count: got %0d outputs, required 10", tag, q_data.size());
      end
      for (int i = 0; i < 10 && i < q_data.size(); i++) begin
         exp = (i < 8) ? 34'(i + 1) : 34'd0;
         n_cmp++;
         if (q_data[i] !== exp || q_phase[i] !== 1'(i % 2)) begin
            n_err++;
            $display("FAIL %s_out[%0d]: data=%0d phase=%0d, required data=%0d phase=%0d",
                     tag, i, q_data[i], q_phase[i], exp, i % 2);
         end
      end
   endtask

   task automatic test_reset();
      arst_n = 0;
      #1;
      n_cmp++;
      if (valid_out !== 1'b0 || data_out !== 34'd0 || phase_out !== 1'b0 || ready_out !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state: valid=%b data=%0d phase=%0d ready_out=%b, required 0 0 0 1",
                  valid_out, data_out, phase_out, ready_out);
      end
      do_reset();
      n_cmp++;
      if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release: valid=%b ready_out=%b, required 0 1", valid_out, ready_out);
      end
   endtask

   task automatic test_impulse();
      run_impulse("impulse");
   endtask

   task automatic test_full_rate();
      logic acc;
      do_reset();
      set_ramp_coeffs();
      ready_in = 1;
      data_in  = 16'd0;
      valid_in = 1;
      acc = 0;
      for (int c = 0; c < 50 && !acc; c++) begin
         @(negedge clk);
         acc = ready_out;
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (!acc) begin
         n_err++;
         $display("FAIL full_rate_accept: first sample not accepted, required acceptance");
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_cmp++;
         if (valid_out !== 1'b1 || ready_out !== 1'(i % 2 == 0)) begin
            n_err++;
            $display("FAIL full_rate[%0d]: valid=%b ready_out=%b, required 1 %b",
                     i, valid_out, ready_out, 1'(i % 2 == 0));
         end
         @(posedge clk);
         #1;
      end
      drain(6);
   endtask

   task automatic test_back_pressure();
      logic acc;
      logic [33:0] exp;
      do_reset();
      set_ramp_coeffs();
      ready_in = 1;
      data_in  = 16'd1;
      valid_in = 1;
      acc = 0;
      for (int c = 0; c < 50 && !acc; c++) begin
         @(negedge clk);
         acc = ready_out;
         @(posedge clk);
         #1;
      end
      data_in = 16'd0;
      @(posedge clk);
      #1;
      ready_in = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (data_out !== 34'd1 || phase_out !== 1'b0 || valid_out !== 1'b1 || ready_out !== 1'b0) begin
            n_err++;
            $display("FAIL stall[%0d]: data=%0d phase=%0d valid=%b ready_out=%b, required 1 0 1 0",
                     i, data_out, phase_out, valid_out, ready_out);
         end
         @(posedge clk);
         #1;
      end
      ready_in = 1;
      in_data = '{16'd0, 16'd0, 16'd0, 16'd0};
      in_byp  = '{0, 0, 0, 0};
      feed();
      drain(6);
      n_cmp++;
      if (q_data.size() !== 10) begin
         n_err++;
         $display("FAIL stall_count: got %0d outputs, required 10", q_data.size());
      end
      for (int i = 0; i < 10 && i < q_data.size(); i++) begin
         exp = (i < 8) ? 34'(i + 1) : 34'd0;
         n_cmp++;
         if (q_data[i] !== exp || q_phase[i] !== 1'(i % 2)) begin
            n_err++;
            $display("FAIL stall_out[%0d]: data=%0d phase=%0d, required data=%0d phase=%0d",
                     i, q_data[i], q_phase[i], exp, i % 2);
         end
      end
   endtask

   task automatic test_bypass();
      logic [33:0] exp [4];
      exp = '{34'd3276800, 34'd0, 34'd500, 34'd800};
      do_reset();
      set_ramp_coeffs();
      ready_in = 1;
      // bypass drops for the second sample while the first is still emitting
      in_data = '{16'd100, 16'd200};
      in_byp  = '{1, 0};
      feed();
      drain(6);
      n_cmp++;
      if (q_data.size() !== 4) begin
         n_err++;
         $display("FAIL bypass_count: got %0d outputs, required 4", q_data.size());
      end
      for (int i = 0; i < 4 && i < q_data.size(); i++) begin
         n_cmp++;
         if (q_data[i] !== exp[i] || q_phase[i] !== 1'(i % 2)) begin
            n_err++;
            $display("FAIL bypass_out[%0d]: data=%0d phase=%0d, required data=%0d phase=%0d",
                     i, q_data[i], q_phase[i], exp[i], i % 2);
         end
      end
   endtask

   task automatic test_extremes();
      logic [33:0] exp;
      do_reset();
      for (int j = 0; j < 8; j++) coeff[j*16 +: 16] = 16'h8000;
      ready_in = 1;
      in_data = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
      in_byp  = '{0, 0, 0, 0};
      feed();
      drain(6);
      n_cmp++;
      if (q_data.size() !== 8) begin
         n_err++;
         $display("FAIL extreme_count: got %0d outputs, required 8", q_data.size());
      end
      for (int i = 0; i < 8 && i < q_data.size(); i++) begin
         exp = 34'(longint'(i / 2 + 1) << 30);
         n_cmp++;
         if (q_data[i] !== exp) begin
            n_err++;
            $display("FAIL extreme_out[%0d]: data=%0d, required %0d", i, q_data[i], exp);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      logic acc;
      do_reset();
      set_ramp_coeffs();
      ready_in = 1;
      data_in  = 16'd1;
      valid_in = 1;
      acc = 0;
      for (int c = 0; c < 50 && !acc; c++) begin
         @(negedge clk);
         acc = ready_out;
         @(posedge clk);
         #1;
      end
      valid_in = 0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (valid_out !== 1'b1 || data_out !== 34'd1) begin
         n_err++;
         $display("FAIL midburst_pre: valid=%b data=%0d, required 1 1", valid_out, data_out);
      end
      arst_n = 0;
      #1;
      n_cmp++;
      if (valid_out !== 1'b0 || data_out !== 34'd0 || ready_out !== 1'b1) begin
         n_err++;
         $display("FAIL midburst_reset: valid=%b data=%0d ready_out=%b, required 0 0 1",
                  valid_out, data_out, ready_out);
      end
      run_impulse("post_reset");
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_full_rate();
      test_back_pressure();
      test_bypass();
      test_extremes();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fir_interp_polyphase.md
Name: fir_interp_polyphase

Overview:
Parametrised polyphase interpolating FIR, the successor to the single-rate FIR in the interpolator chain.
- Each accepted input sample produces INTERP_FACTOR output samples, one per polyphase branch.
- Full valid/ready handshake on both sides, with real backpressure.
- Registered output.
- Bypass mode acts as a plain zero-stuffing upsampler.

Parameters:
- INPUT_WORD_SIZE, 16: signed input sample width.
- COEFF_WORD_SIZE, 16: signed coefficient width; unity gain = 2^(COEFF_WORD_SIZE-1).
- N_COEFFS, 8: total prototype filter taps; must be a multiple of INTERP_FACTOR.
- INTERP_FACTOR, 2: interpolation factor L; must be >= 2.
- localparam TAPS = N_COEFFS/INTERP_FACTOR: taps per phase, also the delay-line depth.
- localparam OUTPUT_WORD_SIZE = INPUT_WORD_SIZE+COEFF_WORD_SIZE+$clog2(TAPS).
- localparam PW = $clog2(INTERP_FACTOR).

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- bypass  in  1  1 = zero-stuff upsample; 0 = filter. Latched when a sample is accepted.
- coeff  in  N_COEFFS*COEFF_WORD_SIZE  flat signed coefficient bus; coeff j = [j*COEFF_WORD_SIZE +: COEFF_WORD_SIZE]. Quasi-static.
- data_in  in  INPUT_WORD_SIZE  signed input sample.
- valid_in  in  1  input sample valid.
- ready_out  out  1  block can accept data_in this cycle.
- data_out  out  OUTPUT_WORD_SIZE  signed output sample, registered.
- phase_out  out  PW  polyphase index of data_out, registered.
- valid_out  out  1  data_out valid, registered.
- ready_in  in  1  downstream accepts data_out.

Behaviour:
- Reset state: arst_n is asynchronous and active-low; clock is clk.
  - Delay line, data_out, phase_out, valid_out and the latched bypass all reset to 0.
  - FSM resets to IDLE with phase counter 0.
  - Reset mid-burst drops pending phases silently. After release the first output comes only from a newly accepted sample.
- Handshakes:
  - Input transfer occurs when valid_in && ready_out.
  - Output transfer occurs when valid_out && ready_in.
  - ld = !valid_out || ready_in. The output register may load only when ld is 1.
- Delay line dl[0..TAPS-1]:
  - On an input transfer: dl[0] <= data_in, dl[k] <= dl[k-1].
  - Otherwise it holds.
  - It updates in bypass mode too, so mode switches need no refill.
- FSM states:
  - IDLE:
    - ready_out=1.
    - On an input transfer: go to EMIT with phase=0, and latch bypass.
  - EMIT, when ld:
    - data_out <= y(phase), phase_out <= phase, valid_out <= 1, phase++.
    - On loading phase INTERP_FACTOR-1: phase <= 0. Next state is EMIT if an input transfers on the same edge, else IDLE.
  - EMIT, when !ld: hold.
  - ready_out in EMIT = (phase==INTERP_FACTOR-1) && ld. This combinational path from ready_in enables gap-free full-rate output.
  - IDLE with ld: valid_out <= 0.
- Arithmetic:
  - Filter: y(p) = sum over k=0..TAPS-1 of coeff[k*INTERP_FACTOR+p] * dl[k].
  - All products are full-precision signed and sign-extended to OUTPUT_WORD_SIZE before summing. No rounding or saturation; overflow cannot occur.
  - Bypass: y(0) = dl[0] sign-extended and shifted left by COEFF_WORD_SIZE-1. y(p>0) = 0.
- Timing:
  - Latency: input accepted at edge t gives the phase-0 output at edge t+1.
  - Throughput: one input per INTERP_FACTOR cycles and one output per cycle when ready_in=1 continuously.
- Backpressure: ready_in low holds data_out, phase_out and valid_out stable, and holds ready_out low in EMIT. No sample is lost or duplicated.
- Coefficient timing: coeff is sampled at each output load. Changes mid-burst are allowed but affect subsequent phases only.

Test Plan:
1. Impulse response.
   - Setup: L=2, N=8, coeff j = j+1, ready_in=1.
   - Stimulus: input 1 followed by zeros.
   - Required: data_out 1,2,3,4,5,6,7,8 then 0s; phase_out 0,1,0,1,…
2. Full rate.
   - Stimulus: valid_in=1 and ready_in=1 continuously.
   - Required: valid_out stays 1 with no gaps from one cycle after the first acceptance; ready_out pulses 1 of every 2 cycles.
3. Backpressure.
   - Stimulus: drop ready_in for 3 cycles while phase 0 of a sample is presented.
   - Required: data_out and phase_out stable, ready_out=0, all 8 impulse outputs still delivered in order.
4. Bypass.
   - Stimulus: bypass=1, input 100.
   - Required: outputs 3276800 (100<<15) then 0. Toggling bypass mid-burst takes effect on the next sample only.
5. Extremes.
   - Stimulus: all coeff and all inputs = -32768.
   - Required: steady-state y = 4*2^30 = 4294967296 positive in 34 bits, no wrap.
6. Reset mid-burst.
   - Stimulus: assert arst_n low during phase 1.
   - Required: valid_out=0, data_out=0 and ready_out=1 immediately. After release, a new impulse reproduces scenario 1 from the start.
